// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its length decoder.
package fetch_unit_pkg;

    localparam int unsigned FETCH_ADDR_W = 8;
    localparam int unsigned FETCH_DATA_W = 8;

    localparam logic [3:0] OPC_HLT    = 4'hF;
    localparam logic [3:0] OPC_2B_MIN = 4'h8;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Output-stage payload presented to the decoder
    typedef struct packed {
        logic [FETCH_DATA_W-1:0] opcode;
        logic [FETCH_DATA_W-1:0] operand;
        logic                    len;
        logic [FETCH_ADDR_W-1:0] pc;
        logic                    fault;
    } fetch_out_t;

    function automatic logic [FETCH_ADDR_W-1:0] pc_advance(
        input logic [FETCH_ADDR_W-1:0] pc,
        input logic                    is_2byte
    );
        return pc + (is_2byte ? FETCH_ADDR_W'(2) : FETCH_ADDR_W'(1));
    endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Instruction length classifier on the opcode high nibble; shared with the decoder.
module fetch_len_decode
    import fetch_unit_pkg::*;
(
    input  logic [FETCH_DATA_W-1:0] opcode_i,
    output logic                    is_2byte_o,
    output logic                    is_hlt_o
);

    logic [3:0] nib_c;
    logic       unused_lo_c;

    assign nib_c       = opcode_i[7:4];
    assign unused_lo_c = ^opcode_i[3:0];

    // HLT sits above the 2-byte range but is a single byte
    assign is_hlt_o   = (nib_c == OPC_HLT);
    assign is_2byte_o = (nib_c >= OPC_2B_MIN) && (nib_c != OPC_HLT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: PC-driven ROM address, length decode, registered valid/ready stage.
// Optional saturating performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned        DATA_W    = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(0)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic [DATA_W-1:0] imem_next,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opcode,
    output logic [DATA_W-1:0] out_operand,
    output logic              out_len,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fault,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stall
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    fetch_out_t        out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic is_2byte_c;
    logic is_hlt_c;
    logic fault_c;
    logic load_c;

    fetch_len_decode u_len_decode (
        .opcode_i   (imem_instr),
        .is_2byte_o (is_2byte_c),
        .is_hlt_o   (is_hlt_c)
    );

    // A 2-byte op at the last address has no operand byte to fetch
    assign fault_c = is_2byte_c && (pc_q == {ADDR_W{1'b1}});
    assign load_c  = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !redirect_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (redirect_valid) begin
            pc_d        = redirect_addr;
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
        end else if (load_c) begin
            out_d.opcode  = imem_instr;
            out_d.operand = (is_2byte_c && !fault_c) ? imem_next : DATA_W'(0);
            out_d.len     = is_2byte_c;
            out_d.pc      = pc_q;
            out_d.fault   = fault_c;
            out_valid_d   = 1'b1;
            pc_d          = pc_advance(pc_q, is_2byte_c);
            if (is_hlt_c) begin
                state_d = ST_HALTED;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_VEC;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_opcode  = out_q.opcode;
    assign out_operand = out_q.operand;
    assign out_len     = out_q.len;
    assign out_pc      = out_q.pc;
    assign out_fault   = out_q.fault;
    assign halted      = (state_q == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q;
    logic [15:0] perf_stall_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 16'h0000;
            perf_stall_q   <= 16'h0000;
        end else begin
            if (load_c && (perf_fetched_q != 16'hFFFF)) begin
                perf_fetched_q <= perf_fetched_q + 16'd1;
            end
            if (out_valid_q && !out_ready && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
